// File: rtl/add_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : add_seq_if
// Description : Handshake and data bundle for the multi-cycle add/subtract
//               unit.
//               master : requester, drives start/sub/cin/a/b and observes
//                        the status and result.
//               slave  : the arithmetic unit, drives busy/done/sum/carry/
//                        overflow/zero.
//               Ports carried:
//                 start    request a new operation
//                 sub      0 = a+b+cin, 1 = a-b-cin
//                 cin      carry-in / borrow-in
//                 a, b     operands (BUS_WIDTH bits)
//                 busy     operation in progress
//                 done     one-cycle completion pulse
//                 sum      result (BUS_WIDTH bits)
//                 carry    carry-out (add) / not-borrow (sub)
//                 overflow signed two's-complement overflow
//                 zero     sum == 0
// Revision    : 1.0 - initial release
// ============================================================================
interface add_seq_if #(
    parameter int BUS_WIDTH = 16
) ();
    logic                 start;
    logic                 sub;
    logic                 cin;
    logic [BUS_WIDTH-1:0] a;
    logic [BUS_WIDTH-1:0] b;
    logic                 busy;
    logic                 done;
    logic [BUS_WIDTH-1:0] sum;
    logic                 carry;
    logic                 overflow;
    logic                 zero;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, carry, overflow, zero
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, carry, overflow, zero
    );
endinterface
`default_nettype wire

// File: rtl/add_seq.sv
`default_nettype none
// ============================================================================
// Module      : add_seq
// Description : Multi-cycle add/subtract unit. Sums CHUNK_WIDTH bits per
//               clock with a registered carry between chunks, so the adder
//               width is CHUNK_WIDTH rather than BUS_WIDTH.
//               Ports:
//                 clk    system clock, rising edge
//                 reset  synchronous, active-high reset
//                 bus    add_seq_if slave modport (start/sub/cin/a/b in,
//                        busy/done/sum/carry/overflow/zero out)
//               Latency is BUS_WIDTH/CHUNK_WIDTH cycles from the accepting
//               edge to done.
// Revision    : 1.0 - initial release
// ============================================================================
module add_seq #(
    parameter int BUS_WIDTH   = 16,
    parameter int CHUNK_WIDTH = 4
) (
    input wire       clk,
    input wire       reset,
    add_seq_if.slave bus
);

    localparam int c_NCH = BUS_WIDTH / CHUNK_WIDTH;
    localparam int c_KW  = (c_NCH > 1) ? $clog2(c_NCH) : 1;
    localparam logic [c_KW-1:0] c_LAST_K = c_KW'(c_NCH - 1);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_RUN  = 1'b1;

    generate
        if ((BUS_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_chunk
            $error("add_seq: BUS_WIDTH must be an integer multiple of CHUNK_WIDTH");
        end
    endgenerate

    logic [0:0]           r_state;
    logic [c_KW-1:0]      r_k;
    // Operands are shifted right one chunk per cycle so the adder always
    // reads the low chunk; no variable part-select is needed.
    logic [BUS_WIDTH-1:0] r_a;
    logic [BUS_WIDTH-1:0] r_b;
    // Result chunks enter at the top and shift down; after the last chunk
    // the accumulator holds the full sum in place.
    logic [BUS_WIDTH-1:0] r_acc;
    logic                 r_cy;
    // Sign bits of A and B' are kept because the operand registers are
    // shifted away by the time the overflow flag is computed.
    logic                 r_a_msb;
    logic                 r_b_msb;

    logic                 r_done;
    logic [BUS_WIDTH-1:0] r_sum;
    logic                 r_carry;
    logic                 r_overflow;
    logic                 r_zero;

    logic [CHUNK_WIDTH:0]   w_chunk;
    logic [BUS_WIDTH-1:0]   w_acc_next;
    logic [BUS_WIDTH-1:0]   w_b_eff;

    assign w_b_eff = bus.sub ? ~bus.b : bus.b;

    assign w_chunk = {1'b0, r_a[CHUNK_WIDTH-1:0]}
                   + {1'b0, r_b[CHUNK_WIDTH-1:0]}
                   + {{CHUNK_WIDTH{1'b0}}, r_cy};

    assign w_acc_next = (r_acc >> CHUNK_WIDTH)
                      | (BUS_WIDTH'(w_chunk[CHUNK_WIDTH-1:0]) << (BUS_WIDTH - CHUNK_WIDTH));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_S_IDLE;
            r_k        <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_cy       <= 1'b0;
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
            r_done     <= 1'b0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= w_b_eff;
                        r_a_msb <= bus.a[BUS_WIDTH-1];
                        r_b_msb <= w_b_eff[BUS_WIDTH-1];
                        // Subtract is a + ~b + ~borrow, i.e. carry-in = cin ^ sub.
                        r_cy    <= bus.cin ^ bus.sub;
                        r_k     <= '0;
                        r_state <= c_S_RUN;
                    end
                end
                c_S_RUN: begin
                    r_a   <= r_a >> CHUNK_WIDTH;
                    r_b   <= r_b >> CHUNK_WIDTH;
                    r_acc <= w_acc_next;
                    r_cy  <= w_chunk[CHUNK_WIDTH];
                    r_k   <= r_k + c_KW'(1);
                    if (r_k == c_LAST_K) begin
                        r_sum      <= w_acc_next;
                        r_carry    <= w_chunk[CHUNK_WIDTH];
                        r_overflow <= (r_a_msb == r_b_msb)
                                   && (w_acc_next[BUS_WIDTH-1] != r_a_msb);
                        r_zero     <= (w_acc_next == '0);
                        r_done     <= 1'b1;
                        r_state    <= c_S_IDLE;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = (r_state == c_S_RUN);
    assign bus.done     = r_done;
    assign bus.sum      = r_sum;
    assign bus.carry    = r_carry;
    assign bus.overflow = r_overflow;
    assign bus.zero     = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_seq
// Description : Self-checking bench for add_seq. Directed vector table on the
//               default 16/4 configuration, hand-written multi-cycle corner
//               sequences, and a random sweep over 16/16, 16/1 and 32/8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_seq;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    add_seq_if #(.BUS_WIDTH(16)) bus0   ();
    add_seq_if #(.BUS_WIDTH(16)) bus_c16 ();
    add_seq_if #(.BUS_WIDTH(16)) bus_c1  ();
    add_seq_if #(.BUS_WIDTH(32)) bus_w32 ();

    add_seq #(.BUS_WIDTH(16), .CHUNK_WIDTH(4))  u_dut     (.clk(clk), .reset(reset), .bus(bus0));
    add_seq #(.BUS_WIDTH(16), .CHUNK_WIDTH(16)) u_dut_c16 (.clk(clk), .reset(reset), .bus(bus_c16));
    add_seq #(.BUS_WIDTH(16), .CHUNK_WIDTH(1))  u_dut_c1  (.clk(clk), .reset(reset), .bus(bus_c1));
    add_seq #(.BUS_WIDTH(32), .CHUNK_WIDTH(8))  u_dut_w32 (.clk(clk), .reset(reset), .bus(bus_w32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sub;
        logic        cin;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_sum;
        logic        exp_carry;
        logic        exp_ovf;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue0(input logic sub, input logic cin, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus0.start = 1'b1;
        bus0.sub   = sub;
        bus0.cin   = cin;
        bus0.a     = a;
        bus0.b     = b;
        @(posedge clk);
        #1;
        bus0.start = 1'b0;
    endtask

    // Counts edges after the current point until done is seen; -1 on timeout.
    task automatic wait_done0(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus0.done) begin
                lat = i;
                break;
            end
        end
    endtask

    // Reference a +/- b +/- cin at width w (16 or 32).
    task automatic model(input int w, input logic sub, input logic cin,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] s, output logic c,
                         output logic v, output logic z);
        logic [63:0] mask;
        logic [63:0] bp;
        logic [63:0] t;
        mask = (64'd1 << w) - 64'd1;
        bp   = sub ? (~{32'd0, b} & mask) : ({32'd0, b} & mask);
        t    = ({32'd0, a} & mask) + bp + {63'd0, (cin ^ sub)};
        s    = t[31:0] & mask[31:0];
        c    = t[w];
        v    = (a[w-1] == bp[w-1]) && (s[w-1] != a[w-1]);
        z    = (s == 32'd0);
    endtask

    int lat;
    int dcount;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus0.start = 0; bus0.sub = 0; bus0.cin = 0; bus0.a = '0; bus0.b = '0;
        bus_c16.start = 0; bus_c16.sub = 0; bus_c16.cin = 0; bus_c16.a = '0; bus_c16.b = '0;
        bus_c1.start = 0; bus_c1.sub = 0; bus_c1.cin = 0; bus_c1.a = '0; bus_c1.b = '0;
        bus_w32.start = 0; bus_w32.sub = 0; bus_w32.cin = 0; bus_w32.a = '0; bus_w32.b = '0;

        //            sub  cin  a         b         sum       c     v     z
        vecs[0] = '{1'b0, 1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 16'h0010, 16'h0001, 16'h000E, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 16'h00FF, 16'h0000, 16'h0100, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  {63'd0, bus0.busy},     64'd0);
        chk("rst_done",  {63'd0, bus0.done},     64'd0);
        chk("rst_sum",   {48'd0, bus0.sum},      64'd0);
        chk("rst_carry", {63'd0, bus0.carry},    64'd0);
        chk("rst_ovf",   {63'd0, bus0.overflow}, 64'd0);
        chk("rst_zero",  {63'd0, bus0.zero},     64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            issue0(vecs[i].sub, vecs[i].cin, vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_busy", i), {63'd0, bus0.busy}, 64'd1);
            wait_done0(lat);
            chk($sformatf("v%0d_lat", i),   64'(lat), 64'd4);
            chk($sformatf("v%0d_sum", i),   {48'd0, bus0.sum},      {48'd0, vecs[i].exp_sum});
            chk($sformatf("v%0d_carry", i), {63'd0, bus0.carry},    {63'd0, vecs[i].exp_carry});
            chk($sformatf("v%0d_ovf", i),   {63'd0, bus0.overflow}, {63'd0, vecs[i].exp_ovf});
            chk($sformatf("v%0d_zero", i),  {63'd0, bus0.zero},     {63'd0, vecs[i].exp_zero});
            chk($sformatf("v%0d_idle", i),  {63'd0, bus0.busy},     64'd0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_drop", i), {63'd0, bus0.done}, 64'd0);
            chk($sformatf("v%0d_hold", i), {48'd0, bus0.sum}, {48'd0, vecs[i].exp_sum});
        end

        // Start while busy is ignored; operand/mode changes during RUN have no effect
        issue0(1'b0, 1'b0, 16'h1234, 16'h1111);
        bus0.start = 1'b1; bus0.sub = 1'b1; bus0.cin = 1'b1; bus0.a = 16'hFFFF; bus0.b = 16'h0001;
        @(posedge clk);
        #1;
        bus0.start = 1'b0;
        chk("ign_busy", {63'd0, bus0.busy}, 64'd1);
        wait_done0(lat);
        chk("ign_lat", 64'(lat), 64'd3);
        chk("ign_sum", {48'd0, bus0.sum}, 64'h2345);
        chk("ign_carry", {63'd0, bus0.carry}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("ign_no_second", {63'd0, bus0.busy}, 64'd0);

        // Reset two cycles into RUN
        issue0(1'b0, 1'b0, 16'h0001, 16'h0002);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_busy",  {63'd0, bus0.busy},     64'd0);
        chk("mrst_done",  {63'd0, bus0.done},     64'd0);
        chk("mrst_sum",   {48'd0, bus0.sum},      64'd0);
        chk("mrst_carry", {63'd0, bus0.carry},    64'd0);
        chk("mrst_ovf",   {63'd0, bus0.overflow}, 64'd0);
        chk("mrst_zero",  {63'd0, bus0.zero},     64'd0);
        reset = 1'b0;
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus0.done || bus0.busy) dcount++;
        end
        chk("mrst_no_done", 64'(dcount), 64'd0);

        // Back-to-back: start held through the done cycle
        @(negedge clk);
        bus0.start = 1'b1; bus0.sub = 1'b0; bus0.cin = 1'b0;
        bus0.a = 16'h0100; bus0.b = 16'h0023;
        @(posedge clk);
        #1;
        bus0.a = 16'h0F00; bus0.b = 16'h00F0;
        wait_done0(lat);
        chk("b2b_lat1", 64'(lat), 64'd4);
        chk("b2b_sum1", {48'd0, bus0.sum}, 64'h0123);
        @(posedge clk);
        #1;
        bus0.start = 1'b0;
        chk("b2b_busy2", {63'd0, bus0.busy}, 64'd1);
        chk("b2b_done_drop", {63'd0, bus0.done}, 64'd0);
        chk("b2b_hold1", {48'd0, bus0.sum}, 64'h0123);
        wait_done0(lat);
        chk("b2b_lat2", 64'(lat), 64'd4);
        chk("b2b_sum2", {48'd0, bus0.sum}, 64'h0FF0);

        // Parameter sweep with random operands
        for (int op = 0; op < 6; op++) begin
            logic [31:0] ra, rb;
            logic        rs, rc;
            logic [31:0] es;
            logic        ec, ev, ez;
            int          l16, l1, l32;
            logic [31:0] s16, s1, s32;
            logic [2:0]  f16, f1, f32;
            ra = $urandom;
            rb = $urandom;
            rs = op[0];
            rc = op[1];
            if (op == 5) begin ra = 32'hFFFF_FFFF; rb = 32'h0000_0001; rs = 1'b0; rc = 1'b0; end
            @(negedge clk);
            bus_c16.start = 1'b1; bus_c16.sub = rs; bus_c16.cin = rc; bus_c16.a = ra[15:0]; bus_c16.b = rb[15:0];
            bus_c1.start  = 1'b1; bus_c1.sub  = rs; bus_c1.cin  = rc; bus_c1.a  = ra[15:0]; bus_c1.b  = rb[15:0];
            bus_w32.start = 1'b1; bus_w32.sub = rs; bus_w32.cin = rc; bus_w32.a = ra;       bus_w32.b = rb;
            @(posedge clk);
            #1;
            bus_c16.start = 1'b0; bus_c1.start = 1'b0; bus_w32.start = 1'b0;
            l16 = -1; l1 = -1; l32 = -1;
            s16 = '0; s1 = '0; s32 = '0; f16 = '0; f1 = '0; f32 = '0;
            for (int cyc = 1; cyc <= 24; cyc++) begin
                @(posedge clk);
                #1;
                if (bus_c16.done && l16 < 0) begin
                    l16 = cyc; s16 = {16'd0, bus_c16.sum};
                    f16 = {bus_c16.carry, bus_c16.overflow, bus_c16.zero};
                end
                if (bus_c1.done && l1 < 0) begin
                    l1 = cyc; s1 = {16'd0, bus_c1.sum};
                    f1 = {bus_c1.carry, bus_c1.overflow, bus_c1.zero};
                end
                if (bus_w32.done && l32 < 0) begin
                    l32 = cyc; s32 = bus_w32.sum;
                    f32 = {bus_w32.carry, bus_w32.overflow, bus_w32.zero};
                end
            end
            model(16, rs, rc, ra, rb, es, ec, ev, ez);
            chk($sformatf("sw%0d_c16_lat", op), 64'(l16), 64'd1);
            chk($sformatf("sw%0d_c16_sum", op), {32'd0, s16}, {32'd0, es});
            chk($sformatf("sw%0d_c16_flags", op), {61'd0, f16}, {61'd0, ec, ev, ez});
            chk($sformatf("sw%0d_c1_lat", op), 64'(l1), 64'd16);
            chk($sformatf("sw%0d_c1_sum", op), {32'd0, s1}, {32'd0, es});
            chk($sformatf("sw%0d_c1_flags", op), {61'd0, f1}, {61'd0, ec, ev, ez});
            model(32, rs, rc, ra, rb, es, ec, ev, ez);
            chk($sformatf("sw%0d_w32_lat", op), 64'(l32), 64'd4);
            chk($sformatf("sw%0d_w32_sum", op), {32'd0, s32}, {32'd0, es});
            chk($sformatf("sw%0d_w32_flags", op), {61'd0, f32}, {61'd0, ec, ev, ez});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
